// File: rtl/zz_pkg.sv
// Shared constants and the JPEG zigzag table (zigzag index -> raster address).
// The table is also meant for the decoder-side inverse reorder.
package zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

  localparam logic [IDX_W-1:0] ZZ_TAB [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_addr(input logic [IDX_W-1:0] idx);
    return ZZ_TAB[idx];
  endfunction

endpackage

// File: rtl/zz_lut.sv
// Combinational zigzag lookup on the read address path.
module zz_lut
  import zz_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] addr
);

  assign addr = zz_addr(idx);

endmodule

// File: rtl/zigzag_buf.sv
// Ping-pong 8x8 block buffer: raster-order writes in, zigzag-order reads out.
// Each bank carries a full flag; writer only sets it, reader only clears it.
module zigzag_buf
  import zz_pkg::*;
#(
  parameter int BW = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  logic [BW-1:0]    mem [2][BLK_SIZE];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic [IDX_W-1:0] rd_addr;
  logic             wr_fire;
  logic             rd_fire;

  zz_lut u_zz_lut (
    .idx  (rd_cnt),
    .addr (rd_addr)
  );

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_data  = mem[rd_bank][rd_addr];
  assign out_idx   = rd_cnt;
  assign out_last  = out_valid & (rd_cnt == LAST_IDX);

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  // Storage is deliberately not reset; a discarded partial block is harmless.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      // A bank being written is never full, a bank being read always is,
      // so the set above and the clear below cannot hit the same flag.
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LAST_IDX) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_zigzag_buf.sv
// Self-checking bench for zigzag_buf: block-level reference model plus directed scenarios.
module tb_zigzag_buf;

  localparam int BW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [BW-1:0] out_data;
  logic [5:0]    out_idx;

  zigzag_buf #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int zz [64];
  int wr_q [$];
  int part [$];
  int exp_q [$];
  int seen [$];
  int pend = 0;
  int rd_pos = 0;
  int rd_total = 0;
  int last_cnt = 0;
  int last_pos = 0;
  bit wfire_s = 1'b0;
  bit rfire_s = 1'b0;
  bit both_last_seen = 1'b0;
  int wr_prob = 100;
  int rd_prob = 100;
  int rd_budget = 1000000;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Zigzag derived geometrically: walk anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = 8 * r + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = 8 * r + (s - r); k++; end
      end
    end
  endfunction

  task automatic push_block(input int base, input int n);
    for (int i = 0; i < n; i++) wr_q.push_back(base + i);
  endtask

  task automatic wait_reads(input int target, input int lim, input string nm);
    int n;
    n = 0;
    while (rd_total < target && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk(nm, rd_total, target);
  endtask

  // Model: pend = complete unread blocks; exp_q = their coefficients in zigzag order.
  always @(negedge clk) begin
    bit wl;
    bit rl;
    wl = 1'b0;
    rl = 1'b0;
    wfire_s = 1'b0;
    rfire_s = 1'b0;
    if (rst) begin
      pend = 0;
      rd_pos = 0;
      part.delete();
      exp_q.delete();
    end else begin
      chk("in_ready", int'(in_ready), int'(pend < 2));
      chk("out_valid", int'(out_valid), int'(pend > 0));
      if (pend > 0) begin
        chk("out_idx", int'(out_idx), rd_pos);
        chk("out_last", int'(out_last), int'(rd_pos == 63));
        if (exp_q.size() > 0) chk("out_data", int'(out_data), exp_q[0]);
      end else begin
        chk("out_last_idle", int'(out_last), 0);
      end
      if (in_valid && in_ready) begin
        wfire_s = 1'b1;
        part.push_back(int'(in_data));
        if (part.size() == 64) begin
          for (int k = 0; k < 64; k++) exp_q.push_back(part[zz[k]]);
          part.delete();
          pend++;
          wl = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        rfire_s = 1'b1;
        seen.push_back(int'(out_data));
        rd_total++;
        if (out_last) begin
          last_cnt++;
          last_pos = seen.size();
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (rd_pos == 63) begin
          rd_pos = 0;
          pend--;
          rl = 1'b1;
        end else begin
          rd_pos++;
        end
      end
      if (wl && rl) both_last_seen = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (wfire_s) void'(wr_q.pop_front());
    if (rfire_s && rd_budget > 0) rd_budget--;
    in_valid  = (wr_q.size() > 0) && (int'($urandom_range(99)) < wr_prob);
    in_data   = (wr_q.size() > 0) ? BW'(wr_q[0]) : '0;
    out_ready = (rd_budget > 0) && (int'($urandom_range(99)) < rd_prob);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    build_zz();
    chk("zz_pin2", zz[2], 8);
    chk("zz_pin5", zz[5], 2);
    chk("zz_pin15", zz[15], 5);
    chk("zz_pin61", zz[61], 55);
    chk("zz_pin63", zz[63], 63);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);

    // single block, free flowing
    seen.delete();
    last_cnt = 0;
    base = rd_total;
    push_block(0, 64);
    wait_reads(base + 64, 400, "t1_reads");
    chk("t1_count", seen.size(), 64);
    chk("t1_beat0", seen[0], 0);
    chk("t1_beat2", seen[2], 8);
    chk("t1_beat5", seen[5], 2);
    chk("t1_beat15", seen[15], 5);
    chk("t1_beat61", seen[61], 55);
    chk("t1_beat63", seen[63], 63);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_last_pos", last_pos, 64);

    // three blocks against a stalled reader
    rd_prob = 0;
    seen.delete();
    for (int b = 0; b < 3; b++) push_block(1000 + 64 * b, 64);
    repeat (250) @(posedge clk);
    #2;
    chk("t2_in_ready_stall", int'(in_ready), 0);
    chk("t2_blk3_pending", wr_q.size(), 64);
    chk("t2_out_valid", int'(out_valid), 1);
    chk("t2_out_idx", int'(out_idx), 0);
    chk("t2_out_data", int'(out_data), 1000);
    base = rd_total;
    rd_prob = 100;
    wait_reads(base + 192, 800, "t2_reads");
    chk("t2_blk1_first", seen[0], 1000);
    chk("t2_blk2_first", seen[64], 1064);
    chk("t2_blk3_beat2", seen[130], 1136);
    chk("t2_blk3_last", seen[191], 1191);

    // random backpressure on both sides
    wr_prob = 50;
    rd_prob = 50;
    seen.delete();
    base = rd_total;
    for (int b = 0; b < 10; b++) push_block(64 * b, 64);
    wait_reads(base + 640, 20000, "t3_reads");
    chk("t3_count", seen.size(), 640);
    chk("t3_b3_beat1", seen[193], 193);
    chk("t3_b4_beat2", seen[258], 264);
    chk("t3_b9_last", seen[639], 639);
    chk("t3_exp_empty", exp_q.size(), 0);
    wr_prob = 100;
    rd_prob = 100;

    // last write of block 2 coincides with last read of block 1
    rd_prob = 0;
    push_block(2000, 64);
    n = 0;
    while (wr_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    seen.delete();
    both_last_seen = 1'b0;
    base = rd_total;
    push_block(3000, 64);
    rd_prob = 100;
    n = 0;
    while (!both_last_seen && n < 300) begin @(posedge clk); #2; n++; end
    chk("t4_coincident", int'(both_last_seen), 1);
    chk("t4_in_ready", int'(in_ready), 1);
    chk("t4_out_valid", int'(out_valid), 1);
    chk("t4_out_idx", int'(out_idx), 0);
    chk("t4_out_data", int'(out_data), 3000);
    wait_reads(base + 128, 400, "t4_reads");
    chk("t4_blk2_first", seen[64], 3000);
    chk("t4_blk2_beat2", seen[66], 3008);

    // reset in the middle of both sides
    rd_prob = 0;
    push_block(3500, 64);
    n = 0;
    while (wr_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    rd_budget = 20;
    rd_prob = 100;
    push_block(3600, 40);
    n = 0;
    while ((wr_q.size() > 0 || rd_budget > 0) && n < 200) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    #2;
    chk("t5_pre_idx", int'(out_idx), 20);
    chk("t5_pre_valid", int'(out_valid), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_in_ready", int'(in_ready), 1);
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_out_idx", int'(out_idx), 0);
    chk("t5_out_last", int'(out_last), 0);
    rd_budget = 1000000;
    seen.delete();
    base = rd_total;
    push_block(50, 64);
    wait_reads(base + 64, 400, "t5_reads");
    chk("t5_beat0", seen[0], 50);
    chk("t5_beat3", seen[3], 66);
    chk("t5_beat63", seen[63], 113);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
